// File: rtl/monitor_pkg.sv
// Shared types for the end-of-test monitor: FSM state encoding, result bundle and width helper.
package monitor_pkg;

    localparam int XLEN_D     = 32;
    localparam int NUM_REGS_D = 32;
    localparam int REG_AW     = $clog2(NUM_REGS_D);

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_CHECK,
        MON_DONE
    } mon_state_e;

    typedef struct packed {
        logic              pass;
        logic              fail;
        logic              timeout;
        logic [REG_AW-1:0] mis_addr;
        logic [XLEN_D-1:0] mis_got;
        logic [XLEN_D-1:0] mis_exp;
    } mon_result_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/core_test_monitor_shadow_regfile.sv
// Shadow copy of the core register file, written from the snooped WB port and read by the checker.
module shadow_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/core_test_monitor.sv
// End-of-test monitor: shadows WB writes, detects PC self-loop halt or timeout, then scans
// the shadow registers against loaded expected values and reports pass/fail.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   MON_IDLE  | after reset; expected values may be loaded, waiting for start
//   MON_RUN   | program running; counting cycles, shadowing WB, watching PC
//   MON_CHECK | halt seen; comparing one register per cycle, x0 first
//   MON_DONE  | verdict held; expected values may be reloaded, start reruns
module core_test_monitor
    import monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HALT_STABLE    = 4,
    parameter int CNT_W          = 32,
    localparam int AW            = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_we,
    input  logic [AW-1:0]    exp_addr,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             exp_clr,
    input  logic             wb_write_en,
    input  logic [AW-1:0]    wb_rd_addr,
    input  logic [XLEN-1:0]  wb_rd_data,
    input  logic [XLEN-1:0]  if_pc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] wb_count,
    output logic [AW-1:0]    mis_addr,
    output logic [XLEN-1:0]  mis_got,
    output logic [XLEN-1:0]  mis_exp
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int SW = cnt_width(HALT_STABLE);

    mon_state_e      state, state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [SW-1:0]   stable_cnt;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   chk_idx;
    logic            mismatch_q, timeout_q;
    logic [XLEN-1:0] exp_mem [NUM_REGS];
    logic [NUM_REGS-1:0] chk_en;
    logic [XLEN-1:0] shadow_rd;

    logic idle_or_done, start_run, in_run, in_check;
    logic halt, tmo_hit, last_idx, wb_take;

    assign idle_or_done = (state == MON_IDLE) || (state == MON_DONE);
    assign start_run    = idle_or_done && start;
    assign in_run       = (state == MON_RUN);
    assign in_check     = (state == MON_CHECK);
    assign halt         = in_run && (if_pc == pc_q) && (stable_cnt == SW'(HALT_STABLE - 1));
    assign tmo_hit      = in_run && (timer == '0);
    assign last_idx     = (chk_idx == AW'(NUM_REGS - 1));
    assign wb_take      = in_run && wb_write_en && (wb_rd_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MON_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MON_IDLE, MON_DONE: if (start) state_nxt = MON_RUN;
            MON_RUN: begin
                if (halt)         state_nxt = MON_CHECK;
                else if (tmo_hit) state_nxt = MON_DONE;
            end
            MON_CHECK: if (last_idx) state_nxt = MON_DONE;
            default: state_nxt = MON_IDLE;
        endcase
    end

    // Timeout is a down-counter loaded at start; reaching zero marks the last RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            wb_count    <= '0;
            pc_q        <= '0;
            stable_cnt  <= '0;
            timer       <= '0;
            chk_idx     <= '0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mis_addr    <= '0;
            mis_got     <= '0;
            mis_exp     <= '0;
        end else if (start_run) begin
            cycle_count <= '0;
            wb_count    <= '0;
            pc_q        <= '0;
            stable_cnt  <= '0;
            timer       <= TW'(TIMEOUT_CYCLES - 1);
            chk_idx     <= '0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mis_addr    <= '0;
            mis_got     <= '0;
            mis_exp     <= '0;
        end else if (in_run) begin
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (wb_take && (wb_count != '1)) wb_count <= wb_count + CNT_W'(1);
            pc_q       <= if_pc;
            stable_cnt <= (if_pc == pc_q) ? stable_cnt + SW'(1) : '0;
            if (timer != '0) timer <= timer - TW'(1);
            if (tmo_hit && !halt) timeout_q <= 1'b1;
        end else if (in_check) begin
            chk_idx <= chk_idx + AW'(1);
            if (chk_en[chk_idx] && (shadow_rd != exp_mem[chk_idx]) && !mismatch_q) begin
                mismatch_q <= 1'b1;
                mis_addr   <= chk_idx;
                mis_got    <= shadow_rd;
                mis_exp    <= exp_mem[chk_idx];
            end
        end
    end

    // A same-cycle write re-enables its own bit after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_en <= '0;
            for (int i = 0; i < NUM_REGS; i++) exp_mem[i] <= '0;
        end else if (idle_or_done) begin
            if (exp_clr) chk_en <= '0;
            if (exp_we) begin
                exp_mem[exp_addr] <= exp_data;
                chk_en[exp_addr]  <= 1'b1;
            end
        end
    end

    shadow_regfile #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .we    (in_run && wb_write_en),
        .waddr (wb_rd_addr),
        .wdata (wb_rd_data),
        .raddr (chk_idx),
        .rdata (shadow_rd)
    );

    assign busy    = in_run || in_check;
    assign done    = (state == MON_DONE);
    assign pass    = done && !mismatch_q && !timeout_q;
    assign fail    = done && (mismatch_q || timeout_q);
    assign timeout = done && timeout_q;

endmodule
